reg_wb_unit: RTL and testbench

- Write-back initiator for the 16x16-bit register file. It is the single driver of the register file write port: write address, write data, and active-high write strobe.
- Arbitrates two result producers, ALU and MEM, onto that port using valid/ready handshakes. Registers the selected write before it reaches the port.
- Keeps a per-register in-flight counter scoreboard. Decode uses the resulting pending mask to stall on hazards.

---
 rtl/reg_wb_unit_pkg.sv | 17 +
 rtl/reg_wb_unit_if.sv | 48 ++++
 rtl/reg_wb_scoreboard.sv | 108 ++++++++++
 rtl/reg_wb_scoreboard_chk.sv | 20 ++
 rtl/reg_wb_unit.sv | 135 +++++++++++++
 tb/tb_reg_wb_unit.sv | 261 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/reg_wb_unit_pkg.sv
// reg_wb_unit_pkg
//   Shared constants and types for the register-file write-back unit:
//   register address/data widths, register count and the encoding used
//   to name which producer won the write port.
package reg_wb_unit_pkg;

   localparam int ADDR_W   = 4;
   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 16;

   // Which producer owns the write port in a given cycle.
   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_e;

endpackage

// File: rtl/reg_wb_unit_if.sv
// reg_wb_unit_if
//   Bundles the producer handshakes, the decode issue/hazard signals and
//   the register-file write port of reg_wb_unit.
//   master : producers, decode and register file side (drives wbi_*)
//   slave  : the write-back unit (drives wbo_*)
interface reg_wb_unit_if;
   import reg_wb_unit_pkg::*;

   logic                wbi_alu_valid;
   logic [ADDR_W-1:0]   wbi_alu_addr;
   logic [DATA_W-1:0]   wbi_alu_data;
   logic                wbo_alu_ready;

   logic                wbi_mem_valid;
   logic [ADDR_W-1:0]   wbi_mem_addr;
   logic [DATA_W-1:0]   wbi_mem_data;
   logic                wbo_mem_ready;

   logic                wbi_issue_valid;
   logic [ADDR_W-1:0]   wbi_issue_addr;
   logic                wbo_issue_ready;
   logic [NUM_REGS-1:0] wbo_pending;

   logic [ADDR_W-1:0]   wbo_waddr;
   logic [DATA_W-1:0]   wbo_wdata;
   logic                wbo_wrn;

   modport master (
      output wbi_alu_valid, wbi_alu_addr, wbi_alu_data,
      input  wbo_alu_ready,
      output wbi_mem_valid, wbi_mem_addr, wbi_mem_data,
      input  wbo_mem_ready,
      output wbi_issue_valid, wbi_issue_addr,
      input  wbo_issue_ready, wbo_pending,
      input  wbo_waddr, wbo_wdata, wbo_wrn
   );

   modport slave (
      input  wbi_alu_valid, wbi_alu_addr, wbi_alu_data,
      output wbo_alu_ready,
      input  wbi_mem_valid, wbi_mem_addr, wbi_mem_data,
      output wbo_mem_ready,
      input  wbi_issue_valid, wbi_issue_addr,
      output wbo_issue_ready, wbo_pending,
      output wbo_waddr, wbo_wdata, wbo_wrn
   );

endinterface

// File: rtl/reg_wb_scoreboard.sv
// reg_wb_scoreboard
//   Per-register in-flight write counters. Decode increments a counter when
//   it issues an instruction targeting that register; the write-back port
//   decrements it when the result retires.
//   clk, rst      : clock, asynchronous active-high reset
//   inc_req       : decode wants to issue a write to inc_addr
//   inc_addr      : destination of the issuing instruction
//   dec_valid     : a write-back transfer happens this cycle to dec_addr
//   dec_addr      : destination of the retiring write
//   inc_ready     : issue accepted (counter not saturated, or freed by retire)
//   pending       : bit r set when counter r is non-zero (registered)
//   dec_underflow : retire targets a register whose counter is zero
module reg_wb_scoreboard
   import reg_wb_unit_pkg::*;
#(
   parameter int CNT_W = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inc_req,
   input  logic [ADDR_W-1:0]   inc_addr,
   input  logic                dec_valid,
   input  logic [ADDR_W-1:0]   dec_addr,
   output logic                inc_ready,
   output logic [NUM_REGS-1:0] pending,
   output logic                dec_underflow
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0]    cnt_r     [NUM_REGS];
   logic [CNT_W-1:0]    cnt_nxt_s [NUM_REGS];
   logic [NUM_REGS-1:0] pending_r;
   logic [NUM_REGS-1:0] pending_nxt_s;
   logic                inc_ready_s;
   logic                underflow_s;

   // Issue acceptance: a same-cycle retire to the same register frees a slot.
   always_comb begin
      inc_ready_s = 1'b0;
      if ((cnt_r[inc_addr] != CNT_MAX) || (dec_valid && (dec_addr == inc_addr))) begin
         inc_ready_s = 1'b1;
      end else begin
         inc_ready_s = 1'b0;
      end
   end

   // Next counter values; retiring from zero leaves the counter at zero.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         logic inc_hit_s;
         logic dec_hit_s;
         inc_hit_s        = inc_req && inc_ready_s && (inc_addr == ADDR_W'(r));
         dec_hit_s        = dec_valid && (dec_addr == ADDR_W'(r));
         cnt_nxt_s[r]     = cnt_r[r];
         case ({inc_hit_s, dec_hit_s})
            2'b10: cnt_nxt_s[r] = cnt_r[r] + CNT_ONE;
            2'b01: begin
               if (cnt_r[r] != CNT_ZERO) begin
                  cnt_nxt_s[r] = cnt_r[r] - CNT_ONE;
               end else begin
                  cnt_nxt_s[r] = CNT_ZERO;
               end
            end
            default: cnt_nxt_s[r] = cnt_r[r];
         endcase
         pending_nxt_s[r] = (cnt_nxt_s[r] != CNT_ZERO);
      end
   end

   // Retire against an idle register, reported to the checker.
   always_comb begin
      underflow_s = 1'b0;
      if (dec_valid && (cnt_r[dec_addr] == CNT_ZERO)) begin
         underflow_s = 1'b1;
      end else begin
         underflow_s = 1'b0;
      end
   end

   // Counter state and the pending mask that mirrors it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_r[r] <= CNT_ZERO;
         end
         pending_r <= {NUM_REGS{1'b0}};
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_r[r] <= cnt_nxt_s[r];
         end
         pending_r <= pending_nxt_s;
      end
   end

   assign inc_ready     = inc_ready_s;
   assign pending       = pending_r;
   assign dec_underflow = underflow_s;

   reg_wb_scoreboard_chk u_chk (
      .clk           (clk),
      .rst           (rst),
      .dec_underflow (underflow_s)
   );

endmodule

// File: rtl/reg_wb_scoreboard_chk.sv
// reg_wb_scoreboard_chk
//   Simulation-only checker for the in-flight scoreboard: flags a
//   write-back that retires a register with no outstanding issue.
//   clk, rst      : scoreboard clock and asynchronous active-high reset
//   dec_underflow : retire strobe hit a zero counter this cycle
module reg_wb_scoreboard_chk (
   input logic clk,
   input logic rst,
   input logic dec_underflow
);

   // A retire on an idle register means a producer wrote without an issue.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!dec_underflow)
            else $warning("reg_wb_scoreboard: write-back to a register with no in-flight issue");
      end
   end

endmodule

// File: rtl/reg_wb_unit.sv
// reg_wb_unit
//   Sole driver of the 16x16 register-file write port. Arbitrates ALU and
//   MEM results (MEM first, ALU force-granted after STARVE_LIMIT blocked
//   cycles), registers the winning write, and tracks in-flight writes per
//   register so decode can stall on hazards.
//   wbi_clk : clock, all state on rising edge
//   wbi_rst : asynchronous active-high reset
//   bus     : producer handshakes, issue/pending, register write port
module reg_wb_unit
   import reg_wb_unit_pkg::*;
#(
   parameter int STARVE_LIMIT = 3,
   parameter int CNT_W        = 2
) (
   input logic           wbi_clk,
   input logic           wbi_rst,
   reg_wb_unit_if.slave  bus
);

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic [3:0]        starve_r;
   logic [3:0]        starve_nxt_s;
   logic              starve_hit_s;
   logic              alu_ready_s;
   logic              mem_ready_s;
   logic              alu_xfer_s;
   logic              mem_xfer_s;
   logic              xfer_s;
   src_e              grant_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_data_s;
   logic              wrn_r;
   logic [ADDR_W-1:0] waddr_r;
   logic [DATA_W-1:0] wdata_r;

   // Readies depend only on the other source and the starve state, so the
   // two transfers can never fire together.
   always_comb begin
      starve_hit_s = (starve_r == STARVE_MAX);
      mem_ready_s  = !(bus.wbi_alu_valid && starve_hit_s);
      alu_ready_s  = !bus.wbi_mem_valid || starve_hit_s;
      alu_xfer_s   = bus.wbi_alu_valid && alu_ready_s;
      mem_xfer_s   = bus.wbi_mem_valid && mem_ready_s;
      xfer_s       = alu_xfer_s || mem_xfer_s;
      if (mem_xfer_s) begin
         grant_s = SRC_MEM;
      end else begin
         grant_s = SRC_ALU;
      end
   end

   // Route the granted producer onto the write path.
   always_comb begin
      sel_addr_s = bus.wbi_alu_addr;
      sel_data_s = bus.wbi_alu_data;
      case (grant_s)
         SRC_ALU: begin
            sel_addr_s = bus.wbi_alu_addr;
            sel_data_s = bus.wbi_alu_data;
         end
         SRC_MEM: begin
            sel_addr_s = bus.wbi_mem_addr;
            sel_data_s = bus.wbi_mem_data;
         end
         default: begin
            sel_addr_s = bus.wbi_alu_addr;
            sel_data_s = bus.wbi_alu_data;
         end
      endcase
   end

   // Count cycles where a waiting ALU result loses to MEM.
   always_comb begin
      starve_nxt_s = 4'd0;
      if (bus.wbi_alu_valid && bus.wbi_mem_valid && mem_xfer_s) begin
         if (starve_r == 4'hF) begin
            starve_nxt_s = starve_r;
         end else begin
            starve_nxt_s = starve_r + 4'd1;
         end
      end else begin
         starve_nxt_s = 4'd0;
      end
   end

   // Starve counter state.
   always_ff @(posedge wbi_clk or posedge wbi_rst) begin
      if (wbi_rst) begin
         starve_r <= 4'd0;
      end else begin
         starve_r <= starve_nxt_s;
      end
   end

   // Write-port register: strobe for one cycle per transfer, address and
   // data hold their last value between writes.
   always_ff @(posedge wbi_clk or posedge wbi_rst) begin
      if (wbi_rst) begin
         wrn_r   <= 1'b0;
         waddr_r <= {ADDR_W{1'b0}};
         wdata_r <= {DATA_W{1'b0}};
      end else begin
         wrn_r <= xfer_s;
         if (xfer_s) begin
            waddr_r <= sel_addr_s;
            wdata_r <= sel_data_s;
         end else begin
            waddr_r <= waddr_r;
            wdata_r <= wdata_r;
         end
      end
   end

   reg_wb_scoreboard #(
      .CNT_W (CNT_W)
   ) u_scoreboard (
      .clk           (wbi_clk),
      .rst           (wbi_rst),
      .inc_req       (bus.wbi_issue_valid),
      .inc_addr      (bus.wbi_issue_addr),
      .dec_valid     (xfer_s),
      .dec_addr      (sel_addr_s),
      .inc_ready     (bus.wbo_issue_ready),
      .pending       (bus.wbo_pending),
      .dec_underflow ()
   );

   assign bus.wbo_alu_ready = alu_ready_s;
   assign bus.wbo_mem_ready = mem_ready_s;
   assign bus.wbo_wrn       = wrn_r;
   assign bus.wbo_waddr     = waddr_r;
   assign bus.wbo_wdata     = wdata_r;

endmodule

// File: tb/tb_reg_wb_unit.sv
// tb_reg_wb_unit
//   Self-checking bench for reg_wb_unit (STARVE_LIMIT=3, CNT_W=2). Expected
//   writes are queued when a transfer is predicted and popped when the
//   write port strobes; readiness and the pending mask come from a small
//   reference model of the arbiter and counters.
module tb_reg_wb_unit;

   logic clk;
   logic rst;

   reg_wb_unit_if bus ();

   reg_wb_unit #(
      .STARVE_LIMIT (3),
      .CNT_W        (2)
   ) dut (
      .wbi_clk (clk),
      .wbi_rst (rst),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [19:0] exp_q[$];
   int          m_cnt [16];
   int          m_starve = 0;

   // Single comparison point.
   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < 16; r++) m_cnt[r] = 0;
      m_starve = 0;
      exp_q.delete();
   endtask

   function automatic logic [15:0] model_pending();
      logic [15:0] p;
      p = 16'h0000;
      for (int r = 0; r < 16; r++) p[r] = (m_cnt[r] != 0);
      return p;
   endfunction

   // One clock cycle with the currently driven inputs.
   task automatic step(output logic g_alu, output logic g_mem);
      logic        hit, ar, mr, ax, mx, ir, inc, dec;
      logic [3:0]  xa, ia;
      logic [15:0] xd;
      logic [19:0] e;
      @(negedge clk);
      hit = (m_starve == 3);
      mr  = !(bus.wbi_alu_valid && hit);
      ar  = !bus.wbi_mem_valid || hit;
      chk_eq("alu_ready", {31'd0, bus.wbo_alu_ready}, {31'd0, ar});
      chk_eq("mem_ready", {31'd0, bus.wbo_mem_ready}, {31'd0, mr});
      ax = bus.wbi_alu_valid && ar;
      mx = bus.wbi_mem_valid && mr;
      xa = mx ? bus.wbi_mem_addr : bus.wbi_alu_addr;
      xd = mx ? bus.wbi_mem_data : bus.wbi_alu_data;
      dec = ax || mx;
      if (bus.wbi_alu_valid && bus.wbi_mem_valid && mx)
         m_starve = (m_starve == 15) ? 15 : m_starve + 1;
      else
         m_starve = 0;
      ia  = bus.wbi_issue_addr;
      ir  = (m_cnt[ia] != 3) || (dec && (xa == ia));
      chk_eq("issue_ready", {31'd0, bus.wbo_issue_ready}, {31'd0, ir});
      inc = bus.wbi_issue_valid && ir;
      if (dec) exp_q.push_back({xa, xd});
      for (int r = 0; r < 16; r++) begin
         logic i_r, d_r;
         i_r = inc && (ia == 4'(r));
         d_r = dec && (xa == 4'(r));
         if (i_r && !d_r) m_cnt[r] = m_cnt[r] + 1;
         else if (d_r && !i_r && m_cnt[r] > 0) m_cnt[r] = m_cnt[r] - 1;
      end
      @(posedge clk);
      #1;
      chk_eq("wrn", {31'd0, bus.wbo_wrn}, {31'd0, dec});
      if (bus.wbo_wrn === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk_eq("unexpected_write", {31'd0, bus.wbo_wrn}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk_eq("waddr", {28'd0, bus.wbo_waddr}, {28'd0, e[19:16]});
            chk_eq("wdata", {16'd0, bus.wbo_wdata}, {16'd0, e[15:0]});
         end
      end
      chk_eq("pending", {16'd0, bus.wbo_pending}, {16'd0, model_pending()});
      g_alu = ax;
      g_mem = mx;
   endtask

   task automatic idle_inputs();
      bus.wbi_alu_valid   = 1'b0;
      bus.wbi_alu_addr    = 4'd0;
      bus.wbi_alu_data    = 16'h0000;
      bus.wbi_mem_valid   = 1'b0;
      bus.wbi_mem_addr    = 4'd0;
      bus.wbi_mem_data    = 16'h0000;
      bus.wbi_issue_valid = 1'b0;
      bus.wbi_issue_addr  = 4'd0;
   endtask

   task automatic issue(input logic [3:0] a);
      logic ga, gm;
      bus.wbi_issue_valid = 1'b1;
      bus.wbi_issue_addr  = a;
      step(ga, gm);
      bus.wbi_issue_valid = 1'b0;
   endtask

   logic        ga, gm;
   logic [3:0]  obs_addr [5];
   logic [3:0]  exp_addr [5];
   int          n_tx, mem_idx, cyc;
   logic        alu_pend;

   initial begin
      exp_addr[0] = 4'd1; exp_addr[1] = 4'd2; exp_addr[2] = 4'd3;
      exp_addr[3] = 4'd9; exp_addr[4] = 4'd4;
      model_clear();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_eq("rst_wrn",     {31'd0, bus.wbo_wrn},     32'd0);
      chk_eq("rst_waddr",   {28'd0, bus.wbo_waddr},   32'd0);
      chk_eq("rst_wdata",   {16'd0, bus.wbo_wdata},   32'd0);
      chk_eq("rst_pending", {16'd0, bus.wbo_pending}, 32'd0);
      rst = 1'b0;

      // Register the destinations used by the following writes.
      issue(4'd5); issue(4'd1); issue(4'd2); issue(4'd3); issue(4'd4); issue(4'd9);

      // ALU alone: one write, latency 1, then the strobe drops.
      bus.wbi_alu_valid = 1'b1;
      bus.wbi_alu_addr  = 4'd5;
      bus.wbi_alu_data  = 16'h1234;
      step(ga, gm);
      chk_eq("alu_only_waddr", {28'd0, bus.wbo_waddr}, 32'd5);
      chk_eq("alu_only_wdata", {16'd0, bus.wbo_wdata}, 32'h1234);
      bus.wbi_alu_valid = 1'b0;
      step(ga, gm);
      chk_eq("alu_only_hold", {16'd0, bus.wbo_wdata}, 32'h1234);

      // Contention: MEM 1..4 against a waiting ALU write to 9.
      n_tx = 0; mem_idx = 0; alu_pend = 1'b1; cyc = 0;
      while (n_tx < 5 && cyc < 20) begin
         bus.wbi_mem_valid = (mem_idx < 4);
         bus.wbi_mem_addr  = 4'(mem_idx + 1);
         bus.wbi_mem_data  = 16'hA000 + 16'(mem_idx + 1);
         bus.wbi_alu_valid = alu_pend;
         bus.wbi_alu_addr  = 4'd9;
         bus.wbi_alu_data  = 16'hB009;
         step(ga, gm);
         if (gm) mem_idx++;
         if (ga) alu_pend = 1'b0;
         if ((ga || gm) && n_tx < 5) begin
            obs_addr[n_tx] = bus.wbo_waddr;
            n_tx++;
         end
         cyc++;
      end
      chk_eq("contention_count", n_tx, 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < n_tx) chk_eq($sformatf("contention_order%0d", i), {28'd0, obs_addr[i]}, {28'd0, exp_addr[i]});
      end
      idle_inputs();

      // Saturate register 7, refuse a fourth issue, then bypass via retire.
      issue(4'd7); issue(4'd7); issue(4'd7);
      chk_eq("p7_set", {31'd0, bus.wbo_pending[7]}, 32'd1);
      bus.wbi_issue_valid = 1'b1;
      bus.wbi_issue_addr  = 4'd7;
      #1;
      chk_eq("p7_sat_ready", {31'd0, bus.wbo_issue_ready}, 32'd0);
      step(ga, gm);
      bus.wbi_mem_valid = 1'b1;
      bus.wbi_mem_addr  = 4'd7;
      bus.wbi_mem_data  = 16'h7007;
      #1;
      chk_eq("p7_bypass_ready", {31'd0, bus.wbo_issue_ready}, 32'd1);
      step(ga, gm);
      bus.wbi_issue_valid = 1'b0;
      step(ga, gm);
      step(ga, gm);
      chk_eq("p7_still_set", {31'd0, bus.wbo_pending[7]}, 32'd1);
      step(ga, gm);
      chk_eq("p7_clear", {31'd0, bus.wbo_pending[7]}, 32'd0);
      idle_inputs();

      // Simultaneous issue and retire on register 4.
      issue(4'd4);
      bus.wbi_issue_valid = 1'b1;
      bus.wbi_issue_addr  = 4'd4;
      bus.wbi_mem_valid   = 1'b1;
      bus.wbi_mem_addr    = 4'd4;
      bus.wbi_mem_data    = 16'h4444;
      step(ga, gm);
      chk_eq("p4_incdec", {31'd0, bus.wbo_pending[4]}, 32'd1);
      bus.wbi_issue_valid = 1'b0;
      step(ga, gm);
      chk_eq("p4_clear", {31'd0, bus.wbo_pending[4]}, 32'd0);
      idle_inputs();

      // Asynchronous reset while a write is on the port.
      issue(4'd10); issue(4'd11);
      bus.wbi_alu_valid = 1'b1;
      bus.wbi_alu_addr  = 4'd10;
      bus.wbi_alu_data  = 16'hAAAA;
      step(ga, gm);
      bus.wbi_alu_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk_eq("arst_wrn",     {31'd0, bus.wbo_wrn},     32'd0);
      chk_eq("arst_pending", {16'd0, bus.wbo_pending}, 32'd0);
      chk_eq("arst_waddr",   {28'd0, bus.wbo_waddr},   32'd0);
      model_clear();
      idle_inputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      issue(4'd12);
      bus.wbi_alu_valid = 1'b1;
      bus.wbi_alu_addr  = 4'd12;
      bus.wbi_alu_data  = 16'hC0DE;
      step(ga, gm);
      chk_eq("post_rst_waddr", {28'd0, bus.wbo_waddr}, 32'd12);
      chk_eq("post_rst_wdata", {16'd0, bus.wbo_wdata}, 32'hC0DE);
      idle_inputs();
      step(ga, gm);

      // Retire to an idle register: the write still reaches the port.
      bus.wbi_mem_valid = 1'b1;
      bus.wbi_mem_addr  = 4'd2;
      bus.wbi_mem_data  = 16'h2222;
      step(ga, gm);
      chk_eq("uf_waddr",   {28'd0, bus.wbo_waddr},      32'd2);
      chk_eq("uf_pending", {31'd0, bus.wbo_pending[2]}, 32'd0);
      idle_inputs();
      step(ga, gm);
      chk_eq("final_pending", {16'd0, bus.wbo_pending}, 32'd0);
      chk_eq("queue_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
